// File: rtl/cla_addsub_seq_if.sv
// Producer/consumer bundle for cla_addsub_seq: operand-word push side and result-word pop side.
interface cla_addsub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        sub;
    logic        first;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        out_last;
    logic        ovf;
    logic        zero;
    logic        seq_err;

    modport master (
        output in_valid, in1, in2, sub, first, last, out_ready,
        input  in_ready, out_valid, Sum, Cout, out_last, ovf, zero, seq_err
    );

    modport slave (
        input  in_valid, in1, in2, sub, first, last, out_ready,
        output in_ready, out_valid, Sum, Cout, out_last, ovf, zero, seq_err
    );
endinterface

// File: rtl/cla_addsub_seq.sv
// FIFO-buffered operand sequencer driving a 16-bit carry-look-ahead adder, one word per cycle,
// with carry chaining for multi-word add/sub. Define CLA_SEQ_FLAGS_EN to build ovf/zero flags.
module cla_addsub_seq #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    cla_addsub_seq_if.slave bus
);

    localparam int unsigned ADDR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        first;
        logic        last;
    } entry_t;

    typedef enum logic {StIdle, StChain} state_e;

    // Carries c[0..4] of a 4-bit look-ahead block; reused at the group level.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c0);
        return c;
    endfunction

    entry_t            mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   count_q;
    logic              full, push, pop;
    entry_t            head;

    state_e state_q, state_d;
    logic   carry_q, sub_q;
    logic   start, seq_err_d, op_sub, cin;

    logic [15:0] bx, g, p, carry, sum;
    logic [3:0]  grp_g, grp_p;
    logic [4:0]  grp_c, blk_c;
    logic        cout;

    logic        out_valid_q, cout_q, last_q, seq_err_q;
    logic [15:0] sum_q;

    // ---------------- input FIFO ----------------
    assign full         = (count_q == FULL_CNT);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = (count_q != '0) && (!out_valid_q || bus.out_ready);
    assign head         = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= '{a: bus.in1, b: bus.in2, sub: bus.sub, first: bus.first,
                             last: bus.last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + ADDR_W'(1);
            if (pop)  rptr_q <= rptr_q + ADDR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- chain FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Any popped word leaves the chain open exactly when it is not the MSW.
    always_comb begin
        state_d = state_q;
        if (pop) state_d = head.last ? StIdle : StChain;
    end

    always_comb begin
        start     = 1'b1;
        seq_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                start     = 1'b1;
                seq_err_d = !head.first;
            end
            StChain: begin
                start     = head.first;
                seq_err_d = head.first;
            end
        endcase
    end

    assign op_sub = start ? head.sub : sub_q;
    assign cin    = start ? head.sub : carry_q;
    assign bx     = op_sub ? ~head.b : head.b;

    // ---------------- 16-bit carry-look-ahead adder ----------------
    always_comb begin
        g     = head.a & bx;
        p     = head.a ^ bx;
        grp_g = '0;
        grp_p = '0;
        carry = '0;
        blk_c = '0;
        for (int k = 0; k < 4; k++) begin
            blk_c    = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            grp_g[k] = blk_c[4];
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c = cla4(grp_g, grp_p, cin);
        for (int k = 0; k < 4; k++) begin
            blk_c            = cla4(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
            carry[4*k +: 4] = blk_c[3:0];
        end
        sum  = p ^ carry;
        cout = grp_c[4];
    end

    // ---------------- chain state and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            last_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (pop) begin
            carry_q     <= cout;
            if (start) sub_q <= head.sub;
            out_valid_q <= 1'b1;
            sum_q       <= sum;
            cout_q      <= cout;
            last_q      <= head.last;
            seq_err_q   <= seq_err_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_last  = last_q;
    assign bus.seq_err   = seq_err_q;

`ifdef CLA_SEQ_FLAGS_EN
    logic zero_q, ovf_q, zero_out_q;
    logic ovf_d, zero_d;

    assign ovf_d  = (head.a[15] == bx[15]) && (sum[15] != head.a[15]);
    assign zero_d = (sum == '0) && (start || zero_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_out_q <= 1'b0;
        end else if (pop) begin
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            zero_out_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_out_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule
